// File: rtl/dm_flush_ctrl_if.sv
// Flush-controller signal bundle: the issue-stage request/response pair,
// the D-cache tag/data array access port and the writeback beat channel.
//
// Handshakes:
//   dm_flush_req/dm_flush_resp is a level 4-phase pair. The requester holds
//   req until it sees resp. The controller holds resp until req drops.
//   The writeback channel is valid/ready. A beat transfers on a rising clk
//   edge where wb_valid && wb_ready. While wb_valid is high and wb_ready is
//   low, wb_addr, wb_data and wb_last stay stable. wb_valid never drops
//   without a transfer, except on reset.
//   Array reads (tag_rd_en, data_rd_en) return their result one cycle later.
interface dm_flush_ctrl_if #(
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 64 - IDX_W - WORD_W - 3;

    logic              dm_flush_req;
    logic              dm_flush_resp;
    logic              flush_busy;
    logic [IDX_W-1:0]  arr_idx;
    logic [WAY_W-1:0]  arr_way;
    logic [WORD_W-1:0] arr_word;
    logic              tag_rd_en;
    logic              tag_rd_valid;
    logic              tag_rd_dirty;
    logic [TAG_W-1:0]  tag_rd_tag;
    logic              data_rd_en;
    logic [63:0]       data_rd_data;
    logic              tag_wr_en;
    logic              tag_wr_valid;
    logic              tag_wr_dirty;
    logic              wb_valid;
    logic [63:0]       wb_addr;
    logic [63:0]       wb_data;
    logic              wb_last;
    logic              wb_ready;

    // The controller side of the bundle.
    modport master (
        input  dm_flush_req, tag_rd_valid, tag_rd_dirty, tag_rd_tag,
               data_rd_data, wb_ready,
        output dm_flush_resp, flush_busy, arr_idx, arr_way, arr_word,
               tag_rd_en, data_rd_en, tag_wr_en, tag_wr_valid, tag_wr_dirty,
               wb_valid, wb_addr, wb_data, wb_last
    );

    // The issue stage, cache arrays and memory side of the bundle.
    modport slave (
        output dm_flush_req, tag_rd_valid, tag_rd_dirty, tag_rd_tag,
               data_rd_data, wb_ready,
        input  dm_flush_resp, flush_busy, arr_idx, arr_way, arr_word,
               tag_rd_en, data_rd_en, tag_wr_en, tag_wr_valid, tag_wr_dirty,
               wb_valid, wb_addr, wb_data, wb_last
    );
endinterface

// File: rtl/dm_flush_ctrl.sv
// D-cache flush responder. On dm_flush_req it walks every set/way of the
// tag array. Each valid+dirty line is read into a line buffer and written
// back as a LINE_WORDS-beat burst, then its dirty bit is cleared.
// dm_flush_resp is raised when the walk is complete.
// Optional build macro DM_FLUSH_INVALIDATE_EN: every valid line is also
// invalidated, so the cache is empty after the flush.
module dm_flush_ctrl #(
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    dm_flush_ctrl_if.master bus,
    output logic [2:0]      dbg_state_o
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam int TAG_W  = 64 - IDX_W - WORD_W - 3;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SETS - 1);
    localparam logic [WAY_W-1:0]  WAY_LAST  = WAY_W'(WAYS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(LINE_WORDS);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LINE_WORDS - 1);
`ifdef DM_FLUSH_INVALIDATE_EN
    localparam logic KEEP_VALID = 1'b0;
`else
    localparam logic KEEP_VALID = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_TAG_RD, S_TAG_CHK, S_FILL, S_WB, S_CLEAN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAY_W-1:0]  way_q, way_d;
    // Counts data reads issued in FILL (0..LINE_WORDS) and beats sent in WB.
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              resp_q, resp_d;
    logic [63:0]       line_q [LINE_WORDS];

    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] fill_wr_idx;
    logic              advance;
    logic              tag_rd_en, data_rd_en, tag_wr_en, wb_valid;

    assign word        = cnt_q[WORD_W-1:0];
    // Data arrives one cycle after its read, so it belongs to the previous word.
    assign fill_wr_idx = word - WORD_W'(1);

    // Resp rises the cycle after DONE is entered. It stays high while req is
    // held. If req is already low on entry it is still shown for one cycle.
    assign resp_d = (state_q == S_DONE) && (bus.dm_flush_req || !resp_q);

    // Next-state, counter updates and array/writeback strobes.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        way_d      = way_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        advance    = 1'b0;
        tag_rd_en  = 1'b0;
        data_rd_en = 1'b0;
        tag_wr_en  = 1'b0;
        wb_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.dm_flush_req) begin
                    idx_d   = '0;
                    way_d   = '0;
                    cnt_d   = '0;
                    state_d = S_TAG_RD;
                end
            end
            S_TAG_RD: begin
                tag_rd_en = 1'b1;
                state_d   = S_TAG_CHK;
            end
            S_TAG_CHK: begin
                if (bus.tag_rd_valid && bus.tag_rd_dirty) begin
                    tag_d   = bus.tag_rd_tag;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
`ifdef DM_FLUSH_INVALIDATE_EN
                else if (bus.tag_rd_valid) begin
                    state_d = S_CLEAN;
                end
`endif
                else begin
                    advance = 1'b1;
                end
            end
            S_FILL: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = S_WB;
                end else begin
                    data_rd_en = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    if (word == WORD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CLEAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CLEAN: begin
                tag_wr_en = 1'b1;
                advance   = 1'b1;
            end
            S_DONE: begin
                if (!bus.dm_flush_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Step to the next way, then the next set; finish after the last line.
        if (advance) begin
            way_d = way_q + WAY_W'(1);
            if (way_q == WAY_LAST) begin
                idx_d = idx_q + IDX_W'(1);
            end
            state_d = (way_q == WAY_LAST && idx_q == IDX_LAST) ? S_DONE : S_TAG_RD;
        end
    end

    // State, walk counters, latched tag and response register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            way_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            resp_q  <= resp_d;
        end
    end

    // Line buffer captures each data word the cycle after its read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else if (state_q == S_FILL && cnt_q != '0) begin
            line_q[fill_wr_idx] <= bus.data_rd_data;
        end
    end

    assign bus.dm_flush_resp = resp_q;
    assign bus.flush_busy    = (state_q != S_IDLE);
    assign bus.arr_idx       = idx_q;
    assign bus.arr_way       = way_q;
    assign bus.arr_word      = word;
    assign bus.tag_rd_en     = tag_rd_en;
    assign bus.data_rd_en    = data_rd_en;
    assign bus.tag_wr_en     = tag_wr_en;
    assign bus.tag_wr_valid  = tag_wr_en & KEEP_VALID;
    assign bus.tag_wr_dirty  = 1'b0;
    assign bus.wb_valid      = wb_valid;
    assign bus.wb_addr       = wb_valid ? {tag_q, idx_q, word, 3'b000} : 64'd0;
    assign bus.wb_data       = wb_valid ? line_q[word] : 64'd0;
    assign bus.wb_last       = wb_valid && (word == WORD_LAST);
    assign dbg_state_o       = 3'(state_q);
endmodule

// File: tb/tb_dm_flush_ctrl.sv
// Bench for dm_flush_ctrl: cache-array/memory responder, wb_ready driver,
// scoreboard of expected writeback beats and tag writes built from a
// line-by-line reference walk of the cache contents.
module tb_dm_flush_ctrl;
    localparam int SETS   = 64;
    localparam int WAYS   = 2;
    localparam int LW     = 4;
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = $clog2(LW);
    localparam int TAG_W  = 64 - IDX_W - WORD_W - 3;
    localparam int TW_W   = IDX_W + WAY_W + 2;
`ifdef DM_FLUSH_INVALIDATE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    dm_flush_ctrl_if #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) bus ();

    dm_flush_ctrl #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Cache contents seen by the controller.
    bit               mvalid [SETS][WAYS];
    bit               mdirty [SETS][WAYS];
    logic [TAG_W-1:0] mtag   [SETS][WAYS];
    logic [63:0]      mdata  [SETS][WAYS][LW];

    logic [128:0]    wb_exp_q[$];   // {last, addr, data}
    logic [TW_W-1:0] tw_exp_q[$];   // {idx, way, valid, dirty}

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int tw_count = 0;
    int stall_seen = 0;
    int stall_cnt = 0;
    bit stall_used = 0;
    int ready_mode = 0;  // 0 always ready, 1 random, 2 stall 3 cycles on beat 1

    bit          prev_pend = 0;
    logic [63:0] prev_addr, prev_data;
    logic        prev_last;

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Tag/data arrays: reads answer one cycle later, tag writes update bits.
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.tag_rd_valid <= 1'b0;
            bus.tag_rd_dirty <= 1'b0;
            bus.tag_rd_tag   <= '0;
            bus.data_rd_data <= '0;
        end else begin
            if (bus.tag_rd_en) begin
                bus.tag_rd_valid <= mvalid[bus.arr_idx][bus.arr_way];
                bus.tag_rd_dirty <= mdirty[bus.arr_idx][bus.arr_way];
                bus.tag_rd_tag   <= mtag[bus.arr_idx][bus.arr_way];
            end
            if (bus.data_rd_en) begin
                bus.data_rd_data <= mdata[bus.arr_idx][bus.arr_way][bus.arr_word];
            end
            if (bus.tag_wr_en) begin
                mvalid[bus.arr_idx][bus.arr_way] = bus.tag_wr_valid;
                mdirty[bus.arr_idx][bus.arr_way] = bus.tag_wr_dirty;
            end
        end
    end

    // wb_ready driver, updated just after each rising edge.
    initial begin
        bus.wb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.wb_ready = 1'b1;
                1: bus.wb_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (bus.wb_valid && bus.wb_addr[WORD_W+2:3] == WORD_W'(1) && !stall_used) begin
                        if (stall_cnt < 3) begin
                            bus.wb_ready = 1'b0;
                            stall_cnt++;
                        end else begin
                            bus.wb_ready = 1'b1;
                            stall_used = 1'b1;
                        end
                    end else begin
                        bus.wb_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every beat handshake and tag write.
    always @(negedge clk) begin
        logic [128:0]    e;
        logic [TW_W-1:0] t;
        if (!rst_n) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend) begin
                check_eq("wb_hold_valid", 64'(bus.wb_valid), 64'd1);
                check_eq("wb_hold_addr", bus.wb_addr, prev_addr);
                check_eq("wb_hold_data", bus.wb_data, prev_data);
                check_eq("wb_hold_last", 64'(bus.wb_last), 64'(prev_last));
            end
            if (bus.wb_valid && bus.wb_ready) begin
                hs_count++;
                if (wb_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got beat addr 0x%0h, expected no beat", bus.wb_addr);
                end else begin
                    e = wb_exp_q.pop_front();
                    check_eq("wb_addr", bus.wb_addr, e[127:64]);
                    check_eq("wb_data", bus.wb_data, e[63:0]);
                    check_eq("wb_last", 64'(bus.wb_last), 64'(e[128]));
                end
            end
            if (bus.wb_valid && !bus.wb_ready) stall_seen++;
            prev_pend = bus.wb_valid && !bus.wb_ready;
            prev_addr = bus.wb_addr;
            prev_data = bus.wb_data;
            prev_last = bus.wb_last;
            if (bus.tag_wr_en) begin
                tw_count++;
                if (tw_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tw_unexpected: got write idx %0d way %0d, expected none",
                             bus.arr_idx, bus.arr_way);
                end else begin
                    t = tw_exp_q.pop_front();
                    check_eq("tag_wr", 64'({bus.arr_idx, bus.arr_way, bus.tag_wr_valid, bus.tag_wr_dirty}),
                             64'(t));
                end
            end
        end
    end

    // Reference walk: every line in set-then-way order; dirty lines give a
    // burst and a clean write, valid-clean lines are invalidated when enabled.
    task automatic build_expect(output int exp_lat);
        int          cost;
        logic [63:0] addr;
        cost = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (mvalid[s][w] && mdirty[s][w]) begin
                    for (int k = 0; k < LW; k++) begin
                        addr = (64'(mtag[s][w]) << (IDX_W + WORD_W + 3)) | (64'(s) << (WORD_W + 3))
                             | (64'(k) << 3);
                        wb_exp_q.push_back({(k == LW - 1), addr, mdata[s][w][k]});
                    end
                    tw_exp_q.push_back({IDX_W'(s), WAY_W'(w), !INV_EN, 1'b0});
                    cost += 2 + (LW + 1) + LW + 1;
                end else if (mvalid[s][w] && INV_EN) begin
                    tw_exp_q.push_back({IDX_W'(s), WAY_W'(w), 1'b0, 1'b0});
                    cost += 3;
                end else begin
                    cost += 2;
                end
            end
        end
        exp_lat = 1 + cost;
    endtask

    task automatic fill_mem(input int pct_valid, input int pct_dirty);
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                mvalid[s][w] = ($urandom_range(0, 99) < pct_valid);
                mdirty[s][w] = ($urandom_range(0, 99) < pct_dirty);
                mtag[s][w]   = TAG_W'({$urandom(), $urandom()});
                for (int k = 0; k < LW; k++) mdata[s][w][k] = {$urandom(), $urandom()};
            end
        end
    endtask

    // One complete flush. drop_at>0 drops req that many cycles into the walk.
    task automatic run_flush(input bit chk_lat, input int extra, input int drop_at, input int hold);
        int exp_lat;
        int cnt;
        int hi;
        build_expect(exp_lat);
        @(posedge clk);
        #1 bus.dm_flush_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("first_tag_rd", 64'({bus.tag_rd_en, bus.arr_idx, bus.arr_way}),
                 64'({1'b1, IDX_W'(0), WAY_W'(0)}));
        cnt = 0;
        while (1) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (drop_at > 0 && cnt == drop_at) bus.dm_flush_req = 1'b0;
            if (bus.dm_flush_resp || cnt > 20000) break;
        end
        checks++;
        if (!bus.dm_flush_resp) begin
            errors++;
            $display("FAIL resp_timeout: got no resp after %0d cycles, expected resp", cnt);
        end else begin
            if (chk_lat) check_eq("resp_latency", 64'(cnt), 64'(exp_lat + extra));
            if (drop_at > 0) begin
                hi = 0;
                while (bus.dm_flush_resp && hi < 10) begin
                    hi++;
                    @(negedge clk);
                end
                check_eq("resp_pulse_len", 64'(hi), 64'd1);
                check_eq("busy_after_pulse", 64'(bus.flush_busy), 64'd0);
            end else begin
                for (int i = 0; i < hold; i++) begin
                    check_eq("resp_held", 64'(bus.dm_flush_resp), 64'd1);
                    @(negedge clk);
                end
                bus.dm_flush_req = 1'b0;
                @(negedge clk);
                check_eq("resp_dropped", 64'(bus.dm_flush_resp), 64'd0);
                check_eq("busy_dropped", 64'(bus.flush_busy), 64'd0);
            end
        end
        check_eq("wb_queue_empty", 64'(wb_exp_q.size()), 64'd0);
        check_eq("tw_queue_empty", 64'(tw_exp_q.size()), 64'd0);
        wb_exp_q.delete();
        tw_exp_q.delete();
    endtask

    initial begin
        int lat;
        int n;
        rst_n = 1'b0;
        bus.dm_flush_req = 1'b0;
        fill_mem(0, 50);
        repeat (2) @(negedge clk);
        check_eq("rst_resp", 64'(bus.dm_flush_resp), 64'd0);
        check_eq("rst_busy", 64'(bus.flush_busy), 64'd0);
        check_eq("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check_eq("rst_tag_wr_en", 64'(bus.tag_wr_en), 64'd0);
        check_eq("rst_tag_rd_en", 64'(bus.tag_rd_en), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All lines invalid: no traffic, resp after 1 + 2*SETS*WAYS cycles.
        hs_count = 0;
        tw_count = 0;
        run_flush(1'b1, 0, 0, 3);
        check_eq("invalid_beats", 64'(hs_count), 64'd0);
        check_eq("invalid_tag_writes", 64'(tw_count), 64'd0);

        // Single dirty line at set 5 way 1.
        fill_mem(0, 0);
        mvalid[5][1] = 1'b1;
        mdirty[5][1] = 1'b1;
        mtag[5][1]   = TAG_W'(64'h1234);
        for (int k = 0; k < LW; k++) mdata[5][1][k] = 64'hA0 + 64'(k);
        hs_count = 0;
        tw_count = 0;
        run_flush(1'b1, 0, 0, 2);
        check_eq("dirty_beats", 64'(hs_count), 64'd4);
        check_eq("dirty_tag_writes", 64'(tw_count), 64'd1);
        check_eq("dirty_bit_cleared", 64'(mdirty[5][1]), 64'd0);

        // Same line, beat 1 stalled for 3 cycles.
        mvalid[5][1] = 1'b1;
        mdirty[5][1] = 1'b1;
        hs_count = 0;
        stall_seen = 0;
        stall_cnt = 0;
        stall_used = 1'b0;
        ready_mode = 2;
        run_flush(1'b1, 3, 0, 1);
        check_eq("stall_cycles", 64'(stall_seen), 64'd3);
        check_eq("stall_beats", 64'(hs_count), 64'd4);

        // Request dropped 10 cycles into a random walk.
        ready_mode = 1;
        fill_mem(40, 40);
        run_flush(1'b0, 0, 10, 0);

        // Reset while beat 2 of a line is presented.
        ready_mode = 0;
        fill_mem(0, 0);
        mvalid[7][0] = 1'b1;
        mdirty[7][0] = 1'b1;
        build_expect(lat);
        @(posedge clk);
        #1 bus.dm_flush_req = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #2;
            n++;
            if (bus.wb_valid && bus.wb_addr[WORD_W+2:3] == WORD_W'(2)) break;
        end
        check_eq("reached_beat2", 64'(bus.wb_valid && bus.wb_addr[WORD_W+2:3] == WORD_W'(2)), 64'd1);
        rst_n = 1'b0;
        bus.dm_flush_req = 1'b0;
        #1;
        check_eq("async_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check_eq("async_rst_busy", 64'(bus.flush_busy), 64'd0);
        check_eq("async_rst_resp", 64'(bus.dm_flush_resp), 64'd0);
        wb_exp_q.delete();
        tw_exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_idle_busy", 64'(bus.flush_busy), 64'd0);
        hs_count = 0;
        run_flush(1'b1, 0, 0, 1);
        check_eq("post_rst_beats", 64'(hs_count), 64'd4);

        // One valid-clean line plus one dirty line.
        fill_mem(0, 0);
        mvalid[3][0] = 1'b1;
        mvalid[9][1] = 1'b1;
        mdirty[9][1] = 1'b1;
        hs_count = 0;
        tw_count = 0;
        run_flush(1'b1, 0, 0, 2);
        check_eq("mixed_beats", 64'(hs_count), 64'd4);
        check_eq("mixed_tag_writes", 64'(tw_count), INV_EN ? 64'd2 : 64'd1);
        check_eq("mixed_clean_valid", 64'(mvalid[3][0]), INV_EN ? 64'd0 : 64'd1);

        // Random contents with random backpressure.
        ready_mode = 1;
        for (int it = 0; it < 3; it++) begin
            fill_mem($urandom_range(20, 90), $urandom_range(10, 60));
            run_flush(1'b0, 0, 0, $urandom_range(1, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dm_flush_ctrl.md
Name: dm_flush_ctrl

Overview:
- Data-cache flush responder: the far end of the `dm_flush_req` / `dm_flush_resp` handshake driven by the issue stage on fence.i.
- On request, walks every set and way of the D-cache tag array, writes each dirty line back to memory as a LINE_WORDS-beat burst, clears its dirty bit, then acknowledges.
- Sits beside the D-cache arrays; `flush_busy` blocks normal cache traffic while walking.

Parameters:
- SETS, 64, number of cache sets (power of 2, >=2).
- WAYS, 2, associativity (power of 2, >=2).
- LINE_WORDS, 4, 64-bit words per line (power of 2, >=2).
- Derived localparam TAG_W = 64 - log2(SETS) - log2(LINE_WORDS) - 3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dm_flush_req  in  1  flush request, level.
- dm_flush_resp  out  1  flush complete, level (4-phase).
- flush_busy  out  1  high in every state except IDLE.
- arr_idx  out  log2(SETS)  set index for array access.
- arr_way  out  log2(WAYS)  way for array access.
- arr_word  out  log2(LINE_WORDS)  word select for data read.
- tag_rd_en  out  1  tag read strobe; result valid next cycle.
- tag_rd_valid  in  1  line valid bit.
- tag_rd_dirty  in  1  line dirty bit.
- tag_rd_tag  in  TAG_W  line tag.
- data_rd_en  out  1  data read strobe; data valid next cycle.
- data_rd_data  in  64  data word.
- tag_wr_en  out  1  write valid/dirty bits of {arr_idx, arr_way}; tag unchanged.
- tag_wr_valid  out  1  valid bit to write.
- tag_wr_dirty  out  1  dirty bit to write (always 0).
- wb_valid  out  1  writeback beat valid.
- wb_addr  out  64  beat byte address.
- wb_data  out  64  beat data.
- wb_last  out  1  final beat of line.
- wb_ready  in  1  beat accepted when wb_valid && wb_ready.

Behaviour:
- Reset (async, rst_n=0): state IDLE, set/way/word counters 0, all outputs 0. Reset mid-burst truncates the burst; the memory side is reset by the same rst_n.
- IDLE: on dm_flush_req=1, clear counters and go to TAG_RD.
- TAG_RD (1 cycle): tag_rd_en=1 for current {idx,way}.
- TAG_CHK (1 cycle):
  - tag_rd_valid && tag_rd_dirty: latch tag, go to FILL.
  - Otherwise go to NEXT logic (no extra cycle).
  - A clean or invalid line therefore costs exactly 2 cycles.
- FILL: issue data_rd_en for words 0..LINE_WORDS-1 on consecutive cycles and capture each into the line buffer the following cycle. Takes LINE_WORDS+1 cycles.
- WB: present beat k.
  - wb_addr = {tag, idx, k, 3'b000}.
  - wb_data = buffer[k]; wb_last = (k == LINE_WORDS-1).
  - wb_valid, wb_addr, wb_data and wb_last are held stable until wb_ready. Beat k+1 is presented in the cycle after acceptance. No bubbles if wb_ready stays high.
- CLEAN (1 cycle): tag_wr_en=1, tag_wr_dirty=0, tag_wr_valid=1.
- NEXT logic: increment way first, then set. If the last set and last way are done, go to DONE; otherwise go to TAG_RD.
- DONE: dm_flush_resp=1, held while dm_flush_req=1. When dm_flush_req is sampled 0, go to IDLE and drop resp next cycle.
- Request dropped mid-walk: the walk completes anyway. DONE then asserts resp for exactly 1 cycle and returns to IDLE.
- Request still high in IDLE after DONE: cannot occur (DONE waits for the request to drop). A new rising request starts a fresh walk.
- Total latency with all lines clean: resp rises 1 + 2·SETS·WAYS cycles after the clock edge that samples the request in IDLE.
- Counters wrap naturally; no overflow states.

Optional Feature:
- Macro: DM_FLUSH_INVALIDATE_EN.
- Defined:
  - CLEAN writes tag_wr_valid=0.
  - Valid-but-clean lines also take one CLEAN cycle, so they cost 3 cycles.
  - The cache is empty after the flush.
- Undefined: only dirty lines are written; valid bits are preserved; behaviour is as above.

Test Plan:
- All lines invalid, SETS=64, WAYS=2: pulse-hold req -> zero wb beats, no tag_wr_en, resp high 257 cycles after the sampling edge.
- Only set 5 way 1 dirty, tag 0x1234, words A0..A3 -> 4 beats at 0x91A0A0, 0x91A0A8, 0x91A0B0, 0x91A0B8 with data A0..A3. wb_last on the 4th beat only. One tag_wr_en at idx 5 way 1 with dirty=0.
- Same line, wb_ready low for 3 cycles while beat 1 is presented -> wb_valid, wb_addr=0x91A0A8 and data held constant. No beat dropped or duplicated; exactly 4 handshakes.
- Req held high after completion -> resp stays 1 until req drops, then resp=0 next cycle and flush_busy=0. Second case: req dropped at cycle 10 of the walk -> walk finishes, resp high exactly 1 cycle.
- rst_n asserted during WB beat 2 -> wb_valid, flush_busy and resp go 0 without a clock edge. After release, state is IDLE and a new req restarts from set 0 way 0.
- DM_FLUSH_INVALIDATE_EN defined, one valid-clean line plus one dirty line -> both receive tag_wr_en with tag_wr_valid=0; only the dirty line produces beats.
